pwm_counter: RTL and testbench



---
 rtl/pwm_counter.sv | 72 +++++++
 tb/tb_pwm_counter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pwm_counter.sv
// PWM timebase: prescaled up/down counter with inclusive terminal count
// and a registered one-cycle wrap pulse at each period boundary.
module pwm_counter #(
    parameter int CNT_W = 16,
    parameter int PS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] period,
    input  logic [PS_W-1:0]  prescale,
    output logic [CNT_W-1:0] counter_val,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             wrap_q, wrap_d;

    // Next-state: reload beats enable, enable gates the prescaler, prescaler gates the step
    always_comb begin
        cnt_d  = cnt_q;
        ps_d   = ps_q;
        wrap_d = 1'b0;
        if (count_reset) begin
            cnt_d = upnotdown ? {CNT_W{1'b0}} : period;
            ps_d  = {PS_W{1'b0}};
        end else if (!en) begin
            cnt_d = cnt_q;
            ps_d  = ps_q;
        end else if (ps_q >= prescale) begin
            // >= rather than == so a lowered prescale or period never stalls for a full rollover
            ps_d = {PS_W{1'b0}};
            if (upnotdown) begin
                if (cnt_q >= period) begin
                    cnt_d  = {CNT_W{1'b0}};
                    wrap_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    cnt_d  = period;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            ps_d = ps_q + {{(PS_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            ps_q   <= {PS_W{1'b0}};
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ps_q   <= ps_d;
            wrap_q <= wrap_d;
        end
    end

    assign counter_val = cnt_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed self-checking bench for pwm_counter with hand-computed expectations.
module tb_pwm_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        count_reset;
    logic        upnotdown;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] counter_val;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    pwm_counter #(.CNT_W(16), .PS_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .counter_val (counter_val),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int exp_cnt, input int exp_wrap);
        chk({tag, ".cnt"}, {16'd0, counter_val}, exp_cnt);
        chk({tag, ".wrap"}, {31'd0, wrap}, exp_wrap);
    endtask

    initial begin
        // Test 1: reset, then up-count period 5
        rst = 1'b1; en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'd5; prescale = 8'd0;
        tick(); tick();
        chk_state("t1_reset", 0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_state("t1_up", i, 0);
        end
        tick(); chk_state("t1_wrap", 0, 1);
        tick(); chk_state("t1_after", 1, 0);

        // Test 2: period 3, prescale 2 -> each value for 3 clocks, wrap every 12
        count_reset = 1'b1; period = 16'd3; prescale = 8'd2;
        tick(); chk_state("t2_reload", 0, 0);
        count_reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk_state("t2_ps", (i / 3) % 4, (i == 12) ? 1 : 0);
        end

        // Test 3: down count with reload, then direction flip
        upnotdown = 1'b0; period = 16'd4; prescale = 8'd0; count_reset = 1'b1;
        tick(); chk_state("t3_reload", 4, 0);
        count_reset = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk_state("t3_down", i, 0);
        end
        tick(); chk_state("t3_wrap", 4, 1);
        tick(); chk_state("t3_d3", 3, 0);
        tick(); chk_state("t3_d2", 2, 0);
        upnotdown = 1'b1;
        tick(); chk_state("t3_flip", 3, 0);

        // Test 4: period lowered below cnt, then enable freeze preserves prescale phase
        period = 16'd20; count_reset = 1'b1;
        tick(); count_reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_state("t4_at10", 10, 0);
        period = 16'd7;
        tick(); chk_state("t4_lower", 0, 1);
        prescale = 8'd3;
        tick(); tick();
        chk_state("t4_ps2", 0, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state("t4_hold", 0, 0);
        end
        en = 1'b1;
        tick(); chk_state("t4_ps3", 0, 0);
        tick(); chk_state("t4_step", 1, 0);

        // Test 5: prescale lowered below ps_cnt, then rst mid-count
        prescale = 8'd200; count_reset = 1'b1;
        tick(); count_reset = 1'b0;
        for (int i = 0; i < 150; i++) tick();
        chk_state("t5_ps150", 0, 0);
        prescale = 8'd10;
        tick(); chk_state("t5_immediate", 1, 0);
        for (int i = 0; i < 10; i++) tick();
        chk_state("t5_pre11", 1, 0);
        tick(); chk_state("t5_step11", 2, 0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick(); chk_state("t5_rst", 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_state("t5_post10", 0, 0);
        tick(); chk_state("t5_post11", 1, 0);

        // Test 6: period 0 wraps every clock; reload works with en low
        period = 16'd0; prescale = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_state("t6_p0", 0, 1);
        end
        en = 1'b0; upnotdown = 1'b0; period = 16'd9; count_reset = 1'b1;
        tick(); chk_state("t6_reload_noen", 9, 0);
        count_reset = 1'b0;
        tick(); chk_state("t6_hold", 9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
